// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared register map, status bit positions and defaults for the SPI slave
package spi_pkg;

  localparam logic [1:0] ADDR_RX       = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_BYTE_CNT = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN   = 2'd3;

  localparam int ST_SEL     = 0;
  localparam int ST_RX_RDY  = 1;
  localparam int ST_TX_FULL = 2;
  localparam int ST_OVR     = 3;
  localparam int ST_UDR     = 4;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - async input synchroniser with optional single-clk rise/fall pulses
module spi_in_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign level_o = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= level_o;
        end
      end
      assign rise_o = level_o & ~prev_q;
      assign fall_o = ~level_o & prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode 0 slave with CPU byte registers, sticky flags and byte counter
// Optional interrupt output and enable register when SPI_SLAVE_IRQ_EN is defined.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] addr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_ss_n,
  output logic       spi_miso,
  output logic       spi_miso_oe
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic       irq
`endif
);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic sclk_lvl_unused, ss_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d_i(spi_sclk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  // Resets low so a select held low across reset never looks like a new frame.
  spi_in_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .d_i(spi_ss_n),
    .level_o(ss_lvl_unused), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  spi_in_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d_i(spi_mosi),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d, tx_data_q, tx_data_d;
  logic       rx_rdy_q, rx_rdy_d, tx_full_q, tx_full_d;
  logic       ovr_q, ovr_d, udr_q, udr_d;
  logic       miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic [7:0] cpu_do_q, cpu_do_d;
  logic [7:0] status, cfg_rd;
  logic       load_tx, rd_rx, wr_rx, wr_status;
  logic       unused_ok;

  assign unused_ok = ^{addr[7:2], sclk_lvl_unused, ss_lvl_unused, mosi_rise_unused, mosi_fall_unused};

  assign rd_rx     = rd && (addr[1:0] == ADDR_RX);
  assign wr_rx     = wr && (addr[1:0] == ADDR_RX);
  assign wr_status = wr && (addr[1:0] == ADDR_STATUS);

  always_comb begin
    status             = '0;
    status[ST_SEL]     = (state_q == SPI_ACTIVE);
    status[ST_RX_RDY]  = rx_rdy_q;
    status[ST_TX_FULL] = tx_full_q;
    status[ST_OVR]     = ovr_q;
    status[ST_UDR]     = udr_q;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    tx_data_d  = tx_data_q;
    rx_rdy_d   = rx_rdy_q;
    tx_full_d  = tx_full_q;
    ovr_d      = ovr_q;
    udr_d      = udr_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    cpu_do_d   = '0;
    load_tx    = 1'b0;

    // CPU-side clears come first so a coincident set from the SPI side wins.
    if (rd_rx) rx_rdy_d = 1'b0;
    if (wr_status) begin
      if (cpu_di[ST_OVR]) ovr_d = 1'b0;
      if (cpu_di[ST_UDR]) udr_d = 1'b0;
    end

    if (ss_rise) begin
      state_d   = SPI_IDLE;
      bit_cnt_d = '0;
      miso_oe_d = 1'b0;
      miso_d    = 1'b0;
    end else if (ss_fall) begin
      state_d    = SPI_ACTIVE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      miso_oe_d  = 1'b1;
      load_tx    = 1'b1;
    end else if (state_q == SPI_ACTIVE) begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d  = rx_shift_d;
          if (rx_rdy_q) ovr_d = 1'b1;
          rx_rdy_d   = 1'b1;
          byte_cnt_d = byte_cnt_q + 8'd1;
          load_tx    = 1'b1;
        end
      end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
        miso_d     = tx_shift_q[6];
      end
    end

    if (load_tx) begin
      if (tx_full_q) begin
        tx_shift_d = tx_data_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = FILL_BYTE;
        udr_d      = 1'b1;
      end
      miso_d = tx_shift_d[7];
    end

    // Applied after the load so a same-clk write stays pending for the next slot.
    if (wr_rx) begin
      tx_data_d = cpu_di;
      tx_full_d = 1'b1;
    end

    if (rd) begin
      case (addr[1:0])
        ADDR_RX:       cpu_do_d = rx_data_q;
        ADDR_STATUS:   cpu_do_d = status;
        ADDR_BYTE_CNT: cpu_do_d = byte_cnt_q;
        default:       cpu_do_d = cfg_rd;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SPI_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
      tx_full_q  <= 1'b0;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      cpu_do_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_data_q  <= tx_data_d;
      rx_rdy_q   <= rx_rdy_d;
      tx_full_q  <= tx_full_d;
      ovr_q      <= ovr_d;
      udr_q      <= udr_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      cpu_do_q   <= cpu_do_d;
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic [3:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;

  // Enable bits sit at [4:1]; irq follows the flags' next state so it drops with them.
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr && (addr[1:0] == ADDR_IRQ_EN)) irq_en_d = cpu_di[4:1];
    irq_d = |(irq_en_d & {udr_d, ovr_d, ~tx_full_d, rx_rdy_d});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign cfg_rd = {3'b000, irq_en_q, 1'b0};
  assign irq    = irq_q;
`else
  assign cfg_rd = 8'h00;
`endif

  assign cpu_do      = cpu_do_q;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;

endmodule
